// File: rtl/hvac_pkg.sv
// Shared types and default timing for the HVAC plant scheduler.
package hvac_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_HEAT, ST_COOL, ST_GAP} hvac_state_e;

    localparam int DEF_MIN_ON = 8;
    localparam int DEF_GAP    = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible zone after last_grant, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  winner,
    output logic          valid
);
    int j;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        winner = '0;
        j      = 0;
        for (int i = N; i >= 1; i--) begin
            j = int'(last_grant) + i;
            if (j >= N) j = j - N;
            if (eligible[j[IW-1:0]]) begin
                winner             = '0;
                winner[j[IW-1:0]]  = 1'b1;
            end
        end
        valid = |eligible;
    end
endmodule

// File: rtl/hvac_scheduler.sv
// Shares one heater/cooler plant among zones with a minimum on-time per grant
// and a forced off-gap before any heat/cool mode reversal.
module hvac_scheduler
    import hvac_pkg::*;
#(
    parameter int N_ZONES = 4,
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int GAP     = DEF_GAP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic [N_ZONES-1:0] grant,
    output logic               heat_en,
    output logic               cool_en,
    output logic [N_ZONES-1:0] conflict
);
    localparam int IW   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int CMAX = (MIN_ON > GAP) ? MIN_ON : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    hvac_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      last_q, last_d;
    logic [N_ZONES-1:0] grant_d;
    logic               heat_d, cool_d;

    logic [N_ZONES-1:0] eligible, win;
    logic               win_vld, win_heat;
    logic [IW-1:0]      win_idx;

    // Zones asking for both modes are masked until one request drops.
    assign eligible = heat_req ^ cool_req;
    assign win_heat = |(win & heat_req);

    rr_arbiter #(.N(N_ZONES), .IW(IW)) u_arb (
        .eligible  (eligible),
        .last_grant(last_q),
        .winner    (win),
        .valid     (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_ZONES; i++)
            if (win[i]) win_idx = IW'(i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant;
        heat_d  = heat_en;
        cool_d  = cool_en;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = win_heat ? ST_HEAT : ST_COOL;
                    grant_d = win;
                    heat_d  = win_heat;
                    cool_d  = !win_heat;
                    cnt_d   = CW'(MIN_ON - 1);
                    last_d  = win_idx;
                end
            end
            ST_HEAT, ST_COOL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (win_vld && (win_heat == (state_q == ST_HEAT))) begin
                    // Same mode: hand the plant over without switching it off.
                    grant_d = win;
                    cnt_d   = CW'(MIN_ON - 1);
                    last_d  = win_idx;
                end else begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    heat_d  = 1'b0;
                    cool_d  = 1'b0;
                    cnt_d   = CW'(GAP - 1);
                end
            end
            default: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= IW'(N_ZONES - 1);
            grant    <= '0;
            heat_en  <= 1'b0;
            cool_en  <= 1'b0;
            conflict <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant    <= grant_d;
            heat_en  <= heat_d;
            cool_en  <= cool_d;
            conflict <= heat_req & cool_req;
        end
    end
endmodule

// File: tb/tb_hvac_scheduler.sv
// Directed vector table, reset corner cases and a randomized run against a
// cycle-count based model of the plant schedule.
module tb_hvac_scheduler;
    localparam int N      = 4;
    localparam int MIN_ON = 8;
    localparam int GAP    = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] heat_req = '0, cool_req = '0;
    logic [N-1:0] grant, conflict;
    logic         heat_en, cool_en;

    int errors = 0;
    int checks = 0;

    hvac_scheduler #(.N_ZONES(N), .MIN_ON(MIN_ON), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .heat_req(heat_req), .cool_req(cool_req),
        .grant(grant), .heat_en(heat_en), .cool_en(cool_en), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        logic [N-1:0] h, c;
        int           n;
        logic [N-1:0] g;
        logic         he, ce;
        logic [N-1:0] cf;
        string        nm;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [N-1:0] g, input logic he,
                       input logic ce, input logic [N-1:0] cf);
        checks++;
        if (grant !== g || heat_en !== he || cool_en !== ce || conflict !== cf) begin
            errors++;
            $display("FAIL %s t=%0t: got grant=%b heat=%b cool=%b conf=%b, want grant=%b heat=%b cool=%b conf=%b",
                     nm, $time, grant, heat_en, cool_en, conflict, g, he, ce, cf);
        end
    endtask

    task automatic do_reset(input logic [N-1:0] h, input logic [N-1:0] c);
        @(negedge clk);
        rst_n = 1'b0; heat_req = h; cool_req = c;
        #2 chk("reset_state", '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Model: timing is expressed as the absolute cycle at which the next
    // decision is due, rather than as a down-counter.
    int m_mode, m_owner, m_last, m_until, m_cyc;
    logic [N-1:0] m_conf;

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_last = N - 1; m_until = 0; m_cyc = 0; m_conf = '0;
    endtask

    function automatic int pick(input logic [N-1:0] h, input logic [N-1:0] c);
        for (int k = 1; k <= N; k++) begin
            int z;
            z = (m_last + k) % N;
            if (h[z] != c[z]) return z;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] h, input logic [N-1:0] c);
        int w;
        m_cyc++;
        m_conf = h & c;
        if (m_mode == 0) begin
            w = pick(h, c);
            if (w >= 0) begin
                m_mode = h[w] ? 1 : 2; m_owner = w; m_last = w; m_until = m_cyc + MIN_ON;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_cyc == m_until) begin
                w = pick(h, c);
                if (w >= 0 && (h[w] ? 1 : 2) == m_mode) begin
                    m_owner = w; m_last = w; m_until = m_cyc + MIN_ON;
                end else begin
                    m_mode = 3; m_until = m_cyc + GAP;
                end
            end
        end else if (m_cyc == m_until) begin
            m_mode = 0;
        end
    endtask

    task automatic model_chk(input string nm);
        logic [N-1:0] g;
        g = '0;
        if (m_mode == 1 || m_mode == 2) g[m_owner] = 1'b1;
        chk(nm, g, m_mode == 1, m_mode == 2, m_conf);
    endtask

    initial begin
        // single heat zone re-granted to itself, heat_en never drops
        tbl.push_back('{1, 4'b0001, 4'b0000, 16, 4'b0001, 1, 0, 4'b0000, "self_regrant"});
        // two heat zones: direct handoff and back
        tbl.push_back('{1, 4'b0101, 4'b0000, 8, 4'b0001, 1, 0, 4'b0000, "handoff_z0"});
        tbl.push_back('{0, 4'b0101, 4'b0000, 8, 4'b0100, 1, 0, 4'b0000, "handoff_z2"});
        tbl.push_back('{0, 4'b0101, 4'b0000, 8, 4'b0001, 1, 0, 4'b0000, "handoff_back"});
        // heat then cool: gap (4) plus idle (1) between
        tbl.push_back('{1, 4'b0001, 4'b0010, 8, 4'b0001, 1, 0, 4'b0000, "mode_heat"});
        tbl.push_back('{0, 4'b0001, 4'b0010, 5, 4'b0000, 0, 0, 4'b0000, "mode_gap"});
        tbl.push_back('{0, 4'b0001, 4'b0010, 8, 4'b0010, 0, 1, 4'b0000, "mode_cool"});
        // request dropped mid-dwell: full dwell, then gap, then idle
        tbl.push_back('{1, 4'b0001, 4'b0000, 2, 4'b0001, 1, 0, 4'b0000, "drop_early"});
        tbl.push_back('{0, 4'b0000, 4'b0000, 6, 4'b0001, 1, 0, 4'b0000, "drop_hold"});
        tbl.push_back('{0, 4'b0000, 4'b0000, 8, 4'b0000, 0, 0, 4'b0000, "drop_idle"});
        // conflicting zone is flagged and never granted
        tbl.push_back('{1, 4'b0010, 4'b0010, 6, 4'b0000, 0, 0, 4'b0010, "conflict"});
        tbl.push_back('{0, 4'b0110, 4'b0010, 8, 4'b0100, 1, 0, 4'b0010, "conflict_other"});

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset(tbl[r].h, tbl[r].c);
            heat_req = tbl[r].h; cool_req = tbl[r].c;
            for (int k = 0; k < tbl[r].n; k++) begin
                @(posedge clk); #1;
                chk(tbl[r].nm, tbl[r].g, tbl[r].he, tbl[r].ce, tbl[r].cf);
                @(negedge clk);
            end
        end

        // asynchronous reset in the middle of a heat dwell
        do_reset(4'b0001, 4'b0000);
        repeat (3) @(posedge clk);
        #1 chk("pre_async_rst", 4'b0001, 1'b1, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", '0, 1'b0, 1'b0, '0);
        heat_req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_z3", 4'b1000, 1'b1, 1'b0, '0);

        // randomized traffic against the model, with one reset mid-run
        do_reset('0, '0);
        model_reset();
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                rst_n = 1'b0;
                #1 chk("rand_rst", '0, 1'b0, 1'b0, '0);
                rst_n = 1'b1;
                model_reset();
            end
            if ($urandom_range(0, 5) == 0) begin
                heat_req = N'($urandom_range(0, 15));
                cool_req = N'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) cool_req = cool_req & ~heat_req;
            end
            @(posedge clk);
            model_step(heat_req, cool_req);
            #1 model_chk("random");
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
